// File: rtl/keccak_xif_ctrl_if.sv
// Core-side XIF issue/commit/result channels plus the permutation start/done pair,
// bundled for the Keccak sequencing controller.
interface keccak_xif_ctrl_if #(
  parameter int ID_WIDTH = 4
);
  logic                issue_valid_i;
  logic                issue_ready_o;
  logic [31:0]         issue_instr_i;
  logic [ID_WIDTH-1:0] issue_id_i;
  logic                issue_accept_o;

  logic                commit_valid_i;
  logic [ID_WIDTH-1:0] commit_id_i;
  logic                commit_kill_i;

  logic                perm_start_o;
  logic                perm_done_i;

  logic                result_valid_o;
  logic                result_ready_i;
  logic [ID_WIDTH-1:0] result_id_o;

  logic                busy_o;

  modport slave (
    input  issue_valid_i, issue_instr_i, issue_id_i,
    input  commit_valid_i, commit_id_i, commit_kill_i,
    input  perm_done_i, result_ready_i,
    output issue_ready_o, issue_accept_o, perm_start_o,
    output result_valid_o, result_id_o, busy_o
  );

  modport master (
    output issue_valid_i, issue_instr_i, issue_id_i,
    output commit_valid_i, commit_id_i, commit_kill_i,
    output perm_done_i, result_ready_i,
    input  issue_ready_o, issue_accept_o, perm_start_o,
    input  result_valid_o, result_id_o, busy_o
  );
endinterface

// File: rtl/keccak_xif_ctrl.sv
// Keccak XIF sequencer: decodes offloads, keeps accepted IDs in order, and runs one
// permutation per committed head entry, returning in-order results.
module keccak_xif_ctrl #(
  parameter int         ID_WIDTH      = 4,
  parameter int         DEPTH         = 4,
  parameter logic [6:0] KECCAK_OPCODE = 7'b0001011,
  parameter logic [2:0] KECCAK_FUNCT3 = 3'b000
) (
  input logic           clk_i,
  input logic           rst_i,
  keccak_xif_ctrl_if.slave xif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, RUN, RESP} state_e;

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] id_q [DEPTH];
  logic [ID_WIDTH-1:0] id_d [DEPTH];
  logic [DEPTH-1:0]    vld_q, vld_d;
  logic [DEPTH-1:0]    cmt_q, cmt_d;
  logic [DEPTH-1:0]    kil_q, kil_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;

  logic match, full, enq, pop;
  logic head_vld, head_cmt, head_kil;
  logic unused_instr_bits;

  assign unused_instr_bits = ^{xif.issue_instr_i[31:15], xif.issue_instr_i[11:7]};

  always_comb begin
    match = (xif.issue_instr_i[6:0] == KECCAK_OPCODE) &&
            (xif.issue_instr_i[14:12] == KECCAK_FUNCT3);
    full  = (count_q == DEPTH_C);
    enq   = xif.issue_valid_i && !full && match;

    head_vld = vld_q[rd_ptr_q];
    head_cmt = cmt_q[rd_ptr_q];
    head_kil = kil_q[rd_ptr_q];

    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (head_vld && head_cmt) begin
          if (head_kil) pop = 1'b1;
          else          state_d = START;
        end
      end
      START: state_d = RUN;
      RUN: begin
        if (xif.perm_done_i) state_d = RESP;
      end
      RESP: begin
        if (xif.result_ready_i) begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    id_d     = id_q;
    vld_d    = vld_q;
    cmt_d    = cmt_q;
    kil_d    = kil_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      cmt_d[rd_ptr_q] = 1'b0;
      kil_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + 1'b1;
    end
    if (enq) begin
      id_d[wr_ptr_q]  = xif.issue_id_i;
      vld_d[wr_ptr_q] = 1'b1;
      cmt_d[wr_ptr_q] = 1'b0;
      kil_d[wr_ptr_q] = 1'b0;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end

    // Applied after enqueue so a same-cycle commit reaches the new entry too.
    if (xif.commit_valid_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (vld_d[i] && !cmt_d[i] && (id_d[i] == xif.commit_id_i)) begin
          cmt_d[i] = 1'b1;
          kil_d[i] = xif.commit_kill_i;
        end
      end
    end

    case ({enq, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    xif.issue_ready_o  = !full;
    xif.issue_accept_o = match;
    xif.perm_start_o   = (state_q == START);
    xif.result_valid_o = (state_q == RESP);
    xif.result_id_o    = (state_q == RESP) ? id_q[rd_ptr_q] : '0;
    xif.busy_o         = (count_q != '0) || (state_q != IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      vld_q    <= '0;
      cmt_q    <= '0;
      kil_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) id_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      vld_q    <= vld_d;
      cmt_q    <= cmt_d;
      kil_q    <= kil_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) id_q[i] <= id_d[i];
    end
  end

endmodule

// File: tb/tb_keccak_xif_ctrl.sv
// Bench for keccak_xif_ctrl: directed scenarios plus randomized traffic, with a
// scoreboard fed by an in-order instruction model and checked by a separate monitor.
module tb_keccak_xif_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  keccak_xif_ctrl_if #(.ID_WIDTH(4)) xif ();

  keccak_xif_ctrl #(
    .ID_WIDTH(4), .DEPTH(4), .KECCAK_OPCODE(7'b0001011), .KECCAK_FUNCT3(3'b000)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .xif  (xif.slave)
  );

  int checks = 0;
  int errors = 0;

  // Model: outstanding accepted instructions in issue order; expected results queue.
  logic [3:0] m_id [$];
  bit         m_cmt[$];
  bit         m_kil[$];
  logic [3:0] exp_q[$];
  bit         prev_start = 1'b0;

  bit run_wait = 1'b0;
  int dcnt     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic bit is_keccak(input logic [31:0] w);
    return (w & 32'h0000_707F) == 32'h0000_000B;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    xif.issue_valid_i  = 1'b0;
    xif.issue_instr_i  = '0;
    xif.issue_id_i     = '0;
    xif.commit_valid_i = 1'b0;
    xif.commit_id_i    = '0;
    xif.commit_kill_i  = 1'b0;
    xif.perm_done_i    = 1'b0;
    xif.result_ready_i = 1'b0;
  endtask

  // Monitor: samples what the next rising edge will see.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        m_id.delete(); m_cmt.delete(); m_kil.delete(); exp_q.delete();
        prev_start = 1'b0;
      end else begin
        if (xif.issue_valid_i)
          check("accept_decode", xif.issue_accept_o, is_keccak(xif.issue_instr_i));
        if (xif.perm_start_o) begin
          check("start_has_committed_head", exp_q.size() != 0, 1'b1);
          check("start_single_pulse", prev_start, 1'b0);
        end
        prev_start = xif.perm_start_o;
        if (xif.result_valid_o) begin
          if (exp_q.size() == 0) begin
            check("result_unexpected", xif.result_valid_o, 1'b0);
          end else begin
            check("result_id", xif.result_id_o, exp_q[0]);
            if (xif.result_ready_i) void'(exp_q.pop_front());
          end
        end
        if (xif.issue_valid_i && xif.issue_ready_o && is_keccak(xif.issue_instr_i)) begin
          m_id.push_back(xif.issue_id_i);
          m_cmt.push_back(1'b0);
          m_kil.push_back(1'b0);
        end
        if (xif.commit_valid_i) begin
          foreach (m_id[i]) begin
            if (!m_cmt[i] && m_id[i] == xif.commit_id_i) begin
              m_cmt[i] = 1'b1;
              m_kil[i] = xif.commit_kill_i;
            end
          end
        end
        while (m_id.size() > 0 && m_cmt[0]) begin
          if (!m_kil[0]) exp_q.push_back(m_id[0]);
          void'(m_id.pop_front()); void'(m_cmt.pop_front()); void'(m_kil.pop_front());
        end
      end
    end
  end

  task automatic issue(input logic [31:0] instr, input logic [3:0] id);
    xif.issue_valid_i = 1'b1;
    xif.issue_instr_i = instr;
    xif.issue_id_i    = id;
  endtask

  task automatic commit(input logic [3:0] id, input logic kill);
    xif.commit_valid_i = 1'b1;
    xif.commit_id_i    = id;
    xif.commit_kill_i  = kill;
  endtask

  task automatic wait_start(output bit ok);
    int n = 0;
    while (!xif.perm_start_o && n < 20) begin
      tick();
      n++;
    end
    ok = xif.perm_start_o;
    if (!ok) check("start_timeout", 1'b0, 1'b1);
  endtask

  // Finish one permutation for the head, holding result_ready low for 'hold' cycles.
  task automatic run_one(input int hold, input logic [3:0] req_id);
    bit ok;
    wait_start(ok);
    if (!ok) return;
    tick();
    xif.perm_done_i = 1'b1;
    tick();
    xif.perm_done_i = 1'b0;
    check("result_latency", xif.result_valid_o, 1'b1);
    for (int k = 0; k < hold; k++) begin
      check("result_held_valid", xif.result_valid_o, 1'b1);
      check("result_held_id", xif.result_id_o, req_id);
      tick();
    end
    check("result_final_id", xif.result_id_o, req_id);
    xif.result_ready_i = 1'b1;
    tick();
    xif.result_ready_i = 1'b0;
    check("result_dropped", xif.result_valid_o, 1'b0);
  endtask

  task automatic responder(input bit spurious);
    xif.perm_done_i = 1'b0;
    if (run_wait) begin
      if (dcnt == 0) begin
        xif.perm_done_i = 1'b1;
        run_wait = 1'b0;
      end else begin
        dcnt--;
      end
    end else if (spurious && $urandom_range(0, 19) == 0) begin
      xif.perm_done_i = 1'b1;
    end
    if (xif.perm_start_o) begin
      run_wait = 1'b1;
      dcnt = $urandom_range(0, 4);
    end
  endtask

  initial begin
    bit ok;
    bit drained;
    logic [31:0] w;

    idle_inputs();
    rst = 1'b1;
    repeat (3) tick();
    check("rst_issue_ready", xif.issue_ready_o, 1'b1);
    check("rst_perm_start", xif.perm_start_o, 1'b0);
    check("rst_result_valid", xif.result_valid_o, 1'b0);
    check("rst_result_id", xif.result_id_o, 4'd0);
    check("rst_busy", xif.busy_o, 1'b0);
    check("rst_accept", xif.issue_accept_o, 1'b0);
    rst = 1'b0;
    tick();

    // Accept and run
    issue(32'h0000_000B, 4'd3);
    #1;
    check("t1_accept", xif.issue_accept_o, 1'b1);
    check("t1_ready", xif.issue_ready_o, 1'b1);
    tick();
    xif.issue_valid_i = 1'b0;
    commit(4'd3, 1'b0);
    check("t1_busy", xif.busy_o, 1'b1);
    tick();
    xif.commit_valid_i = 1'b0;
    check("t1_start_c1", xif.perm_start_o, 1'b0);
    tick();
    check("t1_start_c2", xif.perm_start_o, 1'b1);
    tick();
    check("t1_start_c3", xif.perm_start_o, 1'b0);
    xif.perm_done_i = 1'b1;
    tick();
    xif.perm_done_i = 1'b0;
    check("t1_result_valid", xif.result_valid_o, 1'b1);
    check("t1_result_id", xif.result_id_o, 4'd3);
    tick();
    check("t1_result_hold", xif.result_valid_o, 1'b1);
    check("t1_result_hold_id", xif.result_id_o, 4'd3);
    xif.result_ready_i = 1'b1;
    tick();
    xif.result_ready_i = 1'b0;
    check("t1_result_gone", xif.result_valid_o, 1'b0);
    check("t1_idle", xif.busy_o, 1'b0);

    // Reject
    issue(32'h0000_100B, 4'd5);
    #1;
    check("t2_accept", xif.issue_accept_o, 1'b0);
    check("t2_ready", xif.issue_ready_o, 1'b1);
    tick();
    xif.issue_valid_i = 1'b0;
    check("t2_busy", xif.busy_o, 1'b0);
    repeat (3) tick();

    // Kill
    issue(32'hABCD_800B, 4'd1);
    tick();
    xif.issue_valid_i = 1'b0;
    commit(4'd1, 1'b1);
    check("t3_busy_enq", xif.busy_o, 1'b1);
    tick();
    xif.commit_valid_i = 1'b0;
    check("t3_busy_flag", xif.busy_o, 1'b1);
    tick();
    check("t3_busy_pop", xif.busy_o, 1'b0);
    check("t3_no_start", xif.perm_start_o, 1'b0);
    repeat (2) tick();

    // Full and back-pressure
    for (int k = 0; k < 4; k++) begin
      issue(32'h0000_000B, 4'(4 + k + (k == 3 ? 1 : 0)));
      tick();
    end
    check("t4_full_ready", xif.issue_ready_o, 1'b0);
    issue(32'h0000_000B, 4'd10);
    tick();
    xif.issue_valid_i = 1'b0;
    check("t4_still_full", xif.issue_ready_o, 1'b0);
    commit(4'd4, 1'b0);
    tick();
    xif.commit_valid_i = 1'b0;
    run_one(3, 4'd4);
    check("t4_ready_back", xif.issue_ready_o, 1'b1);
    commit(4'd5, 1'b1); tick();
    commit(4'd6, 1'b1); tick();
    commit(4'd8, 1'b1); tick();
    xif.commit_valid_i = 1'b0;
    for (int n = 0; n < 10 && xif.busy_o; n++) tick();
    check("t4_drained", xif.busy_o, 1'b0);

    // Out-of-order commit, then same-cycle issue+commit
    issue(32'h0000_000B, 4'd2); tick();
    issue(32'h0000_000B, 4'd7); tick();
    xif.issue_valid_i = 1'b0;
    commit(4'd7, 1'b0); tick();
    check("t5_no_start_7", xif.perm_start_o, 1'b0);
    commit(4'd2, 1'b0); tick();
    xif.commit_valid_i = 1'b0;
    check("t5_no_start_early", xif.perm_start_o, 1'b0);
    run_one(0, 4'd2);
    run_one(0, 4'd7);
    issue(32'h0000_000B, 4'd9);
    commit(4'd9, 1'b0);
    tick();
    xif.issue_valid_i  = 1'b0;
    xif.commit_valid_i = 1'b0;
    run_one(1, 4'd9);

    // Reset mid-RUN
    issue(32'h0000_000B, 4'd12); tick();
    xif.issue_valid_i = 1'b0;
    commit(4'd12, 1'b0); tick();
    xif.commit_valid_i = 1'b0;
    wait_start(ok);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("t6_rst_busy", xif.busy_o, 1'b0);
    check("t6_rst_ready", xif.issue_ready_o, 1'b1);
    check("t6_rst_result", xif.result_valid_o, 1'b0);
    check("t6_rst_start", xif.perm_start_o, 1'b0);
    tick();
    rst = 1'b0;
    xif.perm_done_i = 1'b1;
    tick();
    xif.perm_done_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t6_no_result", xif.result_valid_o, 1'b0);
      check("t6_no_busy", xif.busy_o, 1'b0);
    end

    // Randomized traffic
    run_wait = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      responder(1'b1);
      w = $urandom;
      if ($urandom_range(0, 1) == 1) w = (w & ~32'h0000_707F) | 32'h0000_000B;
      xif.issue_valid_i  = $urandom_range(0, 1);
      xif.issue_instr_i  = w;
      xif.issue_id_i     = 4'($urandom_range(0, 15));
      xif.commit_valid_i = ($urandom_range(0, 2) == 0);
      if (m_id.size() > 0 && $urandom_range(0, 3) != 0)
        xif.commit_id_i = m_id[$urandom_range(0, m_id.size() - 1)];
      else
        xif.commit_id_i = 4'($urandom_range(0, 15));
      xif.commit_kill_i  = ($urandom_range(0, 3) == 0);
      xif.result_ready_i = $urandom_range(0, 1);
    end

    drained = 1'b0;
    for (int cyc = 0; cyc < 600 && !drained; cyc++) begin
      tick();
      responder(1'b0);
      xif.issue_valid_i  = 1'b0;
      xif.result_ready_i = 1'b1;
      if (m_id.size() > 0) begin
        xif.commit_valid_i = 1'b1;
        xif.commit_id_i    = m_id[0];
        xif.commit_kill_i  = $urandom_range(0, 1);
      end else begin
        xif.commit_valid_i = 1'b0;
      end
      drained = !xif.busy_o && exp_q.size() == 0 && m_id.size() == 0 && !run_wait;
    end
    check("drain_timeout", drained, 1'b1);
    idle_inputs();
    repeat (3) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    check("final_busy", xif.busy_o, 1'b0);
    check("final_ready", xif.issue_ready_o, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
